// File: rtl/piso_shift_tx.sv
// piso_shift_tx -- parallel-in, serial-out transmitter.
//
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out
// LSB first, one bit per clock, so that a receiver shifting new bits in at
// its MSB toward bit 0 holds the sent word after the frame. A new word can
// be accepted in the last-bit cycle, so frames stream with no idle gap.
//
// Handshake: a word is transferred on a rising clk edge where
// din_valid=1 and din_ready=1. din_valid with din_ready=0 is ignored; the
// sender holds din/din_valid until accepted. din is only sampled then.
//
// Optional feature: define PISO_SHIFT_TX_PARITY_EN to append an even-parity
// bit (XOR of the accepted word) after din[WIDTH-1]; done and din_ready then
// move to the parity-bit cycle.
//
// Parameters:
//   WIDTH       data word width, 2..32
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   din         parallel word to transmit
//   din_valid   din holds a word to send
//   din_ready   block can accept a word this cycle (combinational)
//   sout        serial data, LSB first (registered)
//   sout_valid  sout carries a frame bit this cycle (registered)
//   busy        frame in progress (registered)
//   done        one-cycle pulse while the last frame bit is on sout (registered)
module piso_shift_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

`ifdef PISO_SHIFT_TX_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int CW = $clog2(FLEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FLEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             started;
  logic             last;
  logic             accept;
  logic             bit_n;

`ifdef PISO_SHIFT_TX_PARITY_EN
  logic par, par_n;
`endif

  // Last-bit cycle of the current frame.
  assign last      = (state == SHIFT) && (cnt == LAST);
  // started keeps din_ready low until the first edge after reset release.
  assign din_ready = started && ((state == IDLE) || last);
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
`ifdef PISO_SHIFT_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SHIFT;
          sreg_n  = din;
          cnt_n   = '0;
`ifdef PISO_SHIFT_TX_PARITY_EN
          par_n   = ^din;
`endif
        end
      end
      SHIFT: begin
        if (last) begin
          if (accept) begin
            // Back-to-back: next word's bit 0 follows without a gap.
            sreg_n = din;
            cnt_n  = '0;
`ifdef PISO_SHIFT_TX_PARITY_EN
            par_n  = ^din;
`endif
          end else begin
            state_n = IDLE;
            sreg_n  = '0;
            cnt_n   = '0;
          end
        end else begin
          sreg_n = sreg >> 1;
          cnt_n  = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bit that will be on sout in the next cycle.
`ifdef PISO_SHIFT_TX_PARITY_EN
  assign bit_n = (cnt_n == CW'(WIDTH)) ? par_n : sreg_n[0];
`else
  assign bit_n = sreg_n[0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      started <= 1'b0;
`ifdef PISO_SHIFT_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      sreg    <= sreg_n;
      cnt     <= cnt_n;
      started <= 1'b1;
`ifdef PISO_SHIFT_TX_PARITY_EN
      par     <= par_n;
`endif
    end
  end

  // Outputs are registered from next-state values so they line up with
  // the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      sout       <= (state_n == SHIFT) ? bit_n : 1'b0;
      sout_valid <= (state_n == SHIFT);
      busy       <= (state_n == SHIFT);
      done       <= (state_n == SHIFT) && (cnt_n == LAST);
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx -- self-checking bench for piso_shift_tx (WIDTH=4).
module tb_piso_shift_tx;
  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         sout;
  logic         sout_valid;
  logic         busy;
  logic         done;

  int n_vec = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx;

  piso_shift_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Receiver model: new bits enter at the MSB and move toward bit 0.
  initial rx = '0;
  always @(posedge clk) if (sout_valid) rx <= {sout, rx[W-1:1]};

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Per-cycle vector: inputs driven during the cycle, outputs expected in it.
  // exp = {din_ready, sout, sout_valid, busy, done}
  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic [4:0]   exp;
  } vec_t;

  vec_t tbl[26];

  initial begin
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;

    // single word 4'b1011
    tbl[0]  = '{1'b1, 4'hB, 5'b10000};
    tbl[1]  = '{1'b0, 4'h0, 5'b01110};
    tbl[2]  = '{1'b0, 4'h0, 5'b01110};
    tbl[3]  = '{1'b0, 4'h0, 5'b00110};
    tbl[4]  = '{1'b0, 4'h0, 5'b11111};
    tbl[5]  = '{1'b0, 4'h0, 5'b10000};
    // back-to-back 4'hA then 4'h5 (5 held while not ready)
    tbl[6]  = '{1'b1, 4'hA, 5'b10000};
    tbl[7]  = '{1'b1, 4'h5, 5'b00110};
    tbl[8]  = '{1'b1, 4'h5, 5'b01110};
    tbl[9]  = '{1'b1, 4'h5, 5'b00110};
    tbl[10] = '{1'b1, 4'h5, 5'b11111};
    tbl[11] = '{1'b0, 4'h0, 5'b01110};
    tbl[12] = '{1'b0, 4'h0, 5'b00110};
    tbl[13] = '{1'b0, 4'h0, 5'b01110};
    tbl[14] = '{1'b0, 4'h0, 5'b10111};
    tbl[15] = '{1'b0, 4'h0, 5'b10000};
    // stall: 4'h0 frame, F offered early, changed to 3 before last bit
    tbl[16] = '{1'b1, 4'h0, 5'b10000};
    tbl[17] = '{1'b0, 4'h0, 5'b00110};
    tbl[18] = '{1'b1, 4'hF, 5'b00110};
    tbl[19] = '{1'b1, 4'h3, 5'b00110};
    tbl[20] = '{1'b1, 4'h3, 5'b10111};
    tbl[21] = '{1'b0, 4'h0, 5'b01110};
    tbl[22] = '{1'b0, 4'h0, 5'b01110};
    tbl[23] = '{1'b0, 4'h0, 5'b00110};
    tbl[24] = '{1'b0, 4'h0, 5'b10111};
    tbl[25] = '{1'b0, 4'h0, 5'b10000};

    // ---------------- reset values ----------------
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", {din_ready, sout, sout_valid, busy, done}, 32'h0);
    end
    rst = 1'b0;
    #1 check("ready_before_edge", {31'b0, din_ready}, 32'h0);
    @(negedge clk);
    check("ready_after_release", {din_ready, sout, sout_valid, busy, done},
          32'h10);

    // ---------------- table-driven sequences ----------------
`ifndef PISO_SHIFT_TX_PARITY_EN
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      din_valid = tbl[i].v;
      din       = tbl[i].d;
      check($sformatf("row%0d", i), {din_ready, sout, sout_valid, busy, done},
            {27'b0, tbl[i].exp});
    end
`endif

    // ---------------- asynchronous reset mid-frame ----------------
    @(negedge clk);
    din = 4'hC;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;            // bit 0 on sout
    @(negedge clk);              // bit 1
    @(negedge clk);              // bit 2
    check("abort_bit2", {31'b0, sout}, 32'h1);
    #1 rst = 1'b1;
    #1 check("abort_async", {din_ready, sout, sout_valid, busy, done}, 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_ready", {din_ready, sout, sout_valid, busy, done}, 32'h10);
    din = 4'h6;
    din_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [W-1:0] w;
      w = 4'h6;
      @(negedge clk);
      din_valid = 1'b0;
      check($sformatf("after_abort_bit%0d", k), {30'b0, sout, sout_valid},
            {30'b0, w[k], 1'b1});
    end

`ifndef PISO_SHIFT_TX_PARITY_EN
    // ---------------- loopback into receiver ----------------
    @(negedge clk);              // last bit of 4'h6 frame passes
    for (int w = 0; w < 16; w++) begin
      int t;
      @(negedge clk);
      din = W'(w);
      din_valid = 1'b1;
      exp_q.push_back(W'(w));
      @(negedge clk);
      din_valid = 1'b0;
      t = 0;
      while (!done && t < 10) begin
        @(negedge clk);
        t++;
      end
      if (!done) begin
        check("loopback_timeout", 32'h0, 32'h1);
        void'(exp_q.pop_front());
      end else begin
        @(posedge clk);
        #1 check($sformatf("loopback_%0h", w), {28'b0, rx},
                 {28'b0, exp_q.pop_front()});
      end
    end
`else
    // ---------------- parity frame ----------------
    @(negedge clk);              // parity cycle of 4'h6 frame passes
    @(negedge clk);
    din = 4'b0111;
    din_valid = 1'b1;
    begin
      logic [4:0] ebits;
      logic [4:0] edone;
      ebits = 5'b10111;          // bit k = k-th bit sent: 1,1,1,0, parity 1
      edone = 5'b10000;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        din_valid = 1'b0;
        check($sformatf("parity_bit%0d", k), {29'b0, sout, sout_valid, done},
              {29'b0, ebits[k], 1'b1, edone[k]});
      end
    end
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
Parallel-in, serial-out transmitter; the counterpart of the team's serial-in, parallel-out receive shift register. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out LSB-first, one bit per clock. Bit order matches the receiver, which shifts new bits in at the MSB toward bit 0. After WIDTH shifts, the receiver's parallel output equals the word sent. Consecutive words stream with no idle cycles between frames.

Parameters:
WIDTH, 4, data word width in bits; legal range 2 to 32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
din  input  WIDTH  parallel word to transmit
din_valid  input  1  din holds a word to send
din_ready  output  1  block can accept a word this cycle
sout  output  1  serial data, LSB first
sout_valid  output  1  sout carries a frame bit this cycle
busy  output  1  frame in progress
done  output  1  one-cycle pulse while the last bit of a frame is on sout

Behaviour:
- Reset (rst=1, asynchronous) sets:
  - state IDLE; shift register 0; bit counter 0
  - sout=0, sout_valid=0, busy=0, done=0
  - din_ready=0 while rst is asserted; din_ready=1 from the first clock edge after rst deasserts.
- All outputs are registered, except din_ready, which is combinational from state and counter.
- Frame length: FLEN = WIDTH, or WIDTH+1 with the optional feature.
- Bit counter width: $clog2(FLEN+1).
- States:
  - IDLE:
    - din_ready=1, sout_valid=0, busy=0, sout=0.
    - An accept is a clock edge with din_valid=1 and din_ready=1.
    - On accept: load din into the shift register, counter=0, go to SHIFT.
  - SHIFT:
    - sout_valid=1, busy=1, sout=shift register bit 0.
    - Each clock: shift right by one (zero fill), counter+1.
    - The last bit is on sout when counter==FLEN-1; done=1 in that cycle only.
    - din_ready=1 only in the last-bit cycle.
    - Last-bit cycle with accept: reload from din, counter=0, stay in SHIFT. The next word's bit 0 follows on the next cycle with no gap; done still pulses.
    - Last-bit cycle without accept: go to IDLE.
- Latency: word accepted at edge N → din[0] on sout for cycle N+1; din[k] in cycle N+1+k.
- din_valid while din_ready=0: ignored, no state change. The sender must hold din and din_valid until accepted.
- din is sampled only at an accept; changes to din at any other time have no effect.
- rst asserted mid-frame: the frame is aborted immediately (asynchronously) and all outputs take reset values. There is no partial-frame resumption.
- done and din_ready may be high in the same cycle; this is the back-to-back case.

Optional Feature:
Macro PISO_SHIFT_TX_PARITY_EN.
- Defined:
  - FLEN=WIDTH+1.
  - After din[WIDTH-1], one extra bit is sent: even parity, the XOR of all din bits captured at accept.
  - done and din_ready move to the parity-bit cycle.
  - Parity is computed at accept and held in a dedicated flop.
- Undefined:
  - FLEN=WIDTH; no parity flop or logic.
  - Frame ends on din[WIDTH-1].

Test Plan:
- Reset values: rst=1 for 3 cycles, then 0 → all outputs 0 during reset; din_ready=1 on the first edge after release; sout_valid stays 0 with din_valid=0.
- Single word: WIDTH=4, accept din=4'b1011 at edge N → sout = 1,1,0,1 in cycles N+1..N+4; sout_valid=1 for exactly those 4 cycles; done=1 only in N+4; din_ready=0 in N+1..N+3 and 1 in N+4 and after.
- Back-to-back: din=4'hA, then din_valid held with 4'h5 → 8 contiguous sout_valid cycles, sout = 0,1,0,1,1,0,1,0; busy never drops; done pulses twice.
- Stall: din_valid=1 with din=4'hF in cycle N+2 of a 4'h0 frame, then din changed to 4'h3 before N+4 → 4'h3 is accepted at N+4; sent bits are 0,0,0,0,1,1,0,0.
- Reset mid-frame: rst pulsed asynchronously during bit 2 of 4'hC → sout, sout_valid and busy go to 0 immediately, without waiting for a clock edge. The next accepted word 4'h6 transmits cleanly as 0,1,1,0.
- Loopback and parity: sout is fed into the receive shift register, for words 0x0..0xF. After 4 shifts, the receiver output equals the sent word. With PISO_SHIFT_TX_PARITY_EN, 4'b0111 is sent as 1,1,1,0 plus parity bit 1, and done is high in the 5th cycle.
